result_uart_reporter: RTL and testbench

// Downstream of secure_voting_machine. Consumes the final tallies and the winner/tie outputs.

---
 rtl/result_uart_reporter.sv | 125 ++++++++++++
 tb/tb_result_uart_reporter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_uart_reporter.sv
// Sends one 6-byte 8N1 summary frame (header, three tallies, winner/tie, XOR checksum)
// when the voting machine enters its result phase or a resend is requested.
module result_uart_reporter #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] count_a,
  input  logic [7:0] count_b,
  input  logic [7:0] count_c,
  input  logic [1:0] winner,
  input  logic       tie_flag,
  input  logic       resend,
  output logic       tx,
  output logic       tx_busy,
  output logic       frame_done
);

  localparam int unsigned   CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [2:0]      byte_q, byte_d;
  logic [5:0][7:0] frame_q, frame_d;
  logic [1:0]      prev_winner_q;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            trigger, bit_end;
  logic [7:0]      info, cur_byte;

  assign info     = {tie_flag, 5'b0, winner};
  assign trigger  = (winner != 2'b11) && ((prev_winner_q == 2'b11) || resend);
  assign bit_end  = (cnt_q == CNT_MAX);
  assign cur_byte = frame_q[byte_q];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_q         <= '0;
      byte_q        <= '0;
      frame_q       <= '0;
      prev_winner_q <= 2'b11;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      byte_q        <= byte_d;
      frame_q       <= frame_d;
      prev_winner_q <= winner;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    frame_d = frame_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (state_q != IDLE) cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        // Snapshot the whole frame so later input changes cannot leak into it.
        if (trigger) begin
          frame_d = {count_a ^ count_b ^ count_c ^ info, info,
                     count_c, count_b, count_a, HEADER};
          busy_d  = 1'b1;
          state_d = START;
          cnt_d   = '0;
          bit_d   = '0;
          byte_d  = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (byte_q < 3'd5) begin
            byte_d  = byte_q + 3'd1;
            state_d = START;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    unique case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = cur_byte[bit_q];
      default: tx = 1'b1;
    endcase
  end

  assign tx_busy    = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_result_uart_reporter.sv
// Bench for result_uart_reporter: cycle-level bit-stream model plus a mid-bit UART
// receiver that decodes frames and checks them against hand-computed byte strings.
module tb_result_uart_reporter;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] count_a = '0, count_b = '0, count_c = '0;
  logic [1:0] winner = 2'b11;
  logic       tie_flag = 1'b0;
  logic       resend = 1'b0;
  logic       tx, tx_busy, frame_done;

  int checks = 0, failures = 0, nprint = 0;
  int busy_cnt = 0, done_cnt = 0;

  // Model: queue of expected tx values, one per cycle of the frame in flight.
  bit         mq[$];
  logic       m_done = 1'b0;
  logic [1:0] m_prev = 2'b11;

  logic [47:0] d1;
  bit          ok1;
  int          n1;

  result_uart_reporter #(.CLKS_PER_BIT(CPB), .HEADER(8'hA5)) dut (
    .clk(clk), .reset_n(reset_n), .count_a(count_a), .count_b(count_b),
    .count_c(count_c), .winner(winner), .tie_flag(tie_flag), .resend(resend),
    .tx(tx), .tx_busy(tx_busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] frame_bytes(input logic [7:0] a, input logic [7:0] b,
                                              input logic [7:0] c, input logic [1:0] w,
                                              input logic t);
    logic [7:0] b4;
    b4 = {t, 5'b0, w};
    return {a ^ b ^ c ^ b4, b4, c, b, a, 8'hA5};
  endfunction

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic m_load(input logic [47:0] f);
    for (int j = 0; j < 6; j++)
      for (int s = 0; s < 10; s++) begin
        bit v;
        v = (s == 0) ? 1'b0 : (s == 9) ? 1'b1 : f[j*8 + s - 1];
        repeat (CPB) mq.push_back(v);
      end
  endtask

  initial forever begin
    @(posedge clk);
    if (reset_n !== 1'b1) begin
      mq.delete();
      m_done = 1'b0;
      m_prev = 2'b11;
    end else begin
      m_done = 1'b0;
      if (mq.size() != 0) begin
        mq.delete(0);
        if (mq.size() == 0) m_done = 1'b1;
      end else if (winner != 2'b11 && (m_prev == 2'b11 || resend))
        m_load(frame_bytes(count_a, count_b, count_c, winner, tie_flag));
      m_prev = winner;
    end
  end

  initial forever begin
    logic exp_tx, exp_busy;
    @(negedge clk);
    exp_tx   = (mq.size() != 0) ? mq[0] : 1'b1;
    exp_busy = (mq.size() != 0);
    checks++;
    if (tx !== exp_tx || tx_busy !== exp_busy || frame_done !== m_done) begin
      failures++;
      if (nprint < 20)
        $display("FAIL cycle_cmp t=%0t tx=%b/%b busy=%b/%b done=%b/%b (actual/expected)",
                 $time, tx, exp_tx, tx_busy, exp_busy, frame_done, m_done);
      nprint++;
    end
    if (tx_busy === 1'b1) busy_cnt++;
    if (frame_done === 1'b1) done_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                            input logic t, input logic [1:0] w);
    winner = 2'b11;
    cyc(2);
    busy_cnt = 0;
    done_cnt = 0;
    count_a = a; count_b = b; count_c = c; tie_flag = t; winner = w;
  endtask

  // Mid-bit receiver: finds the first start cycle, then records 240 cycles of tx.
  task automatic rx_frame(output logic [47:0] data, output bit ok, output int n);
    logic cap [240];
    ok = 1'b0; data = '0; n = 0;
    @(negedge clk);
    while (tx !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) return;
    cap[0] = tx;
    for (int i = 1; i < 240; i++) begin
      @(negedge clk);
      cap[i] = tx;
    end
    ok = 1'b1;
    for (int j = 0; j < 6; j++) begin
      if (cap[j*40 + 2] !== 1'b0) ok = 1'b0;
      for (int k = 0; k < 8; k++) data[j*8 + k] = cap[j*40 + 4 + 4*k + 2];
      if (cap[j*40 + 38] !== 1'b1) ok = 1'b0;
    end
  endtask

  task automatic wait_done(output bit ok);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 3000);
    ok = (frame_done === 1'b1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((mq.size() != 0 || tx_busy !== 1'b0) && n < 1000) begin
      cyc(1);
      n++;
    end
    check("idle_timeout", 48'(n < 1000), 48'd1);
  endtask

  initial begin
    cyc(3);
    @(negedge clk);
    check("rst_tx", 48'(tx), 48'd1);
    check("rst_busy", 48'(tx_busy), 48'd0);
    check("rst_done", 48'(frame_done), 48'd0);
    cyc(1);
    reset_n = 1'b1;
    busy_cnt = 0; done_cnt = 0;

    // 1: no result yet, resend pulses must do nothing
    repeat (10) begin
      resend = 1'b1; cyc(1); resend = 1'b0; cyc(3);
    end
    check("t1_busy_cycles", 48'(busy_cnt), 48'd0);
    check("t1_done_pulses", 48'(done_cnt), 48'd0);

    check("model_bytes_t2", frame_bytes(8'd3, 8'd5, 8'd1, 2'b01, 1'b0), 48'h06_01_01_05_03_A5);
    check("model_bytes_t3", frame_bytes(8'd4, 8'd4, 8'd2, 2'b00, 1'b1), 48'h82_80_02_04_04_A5);

    // 2
    set_inputs(8'd3, 8'd5, 8'd1, 1'b0, 2'b01);
    rx_frame(d1, ok1, n1);
    check("t2_rx_ok", 48'(ok1), 48'd1);
    check("t2_bytes", d1, 48'h06_01_01_05_03_A5);
    wait_done(ok1);
    check("t2_done_seen", 48'(ok1), 48'd1);
    cyc(3);
    check("t2_busy_cycles", 48'(busy_cnt), 48'd240);
    check("t2_done_pulses", 48'(done_cnt), 48'd1);

    // 3
    set_inputs(8'd4, 8'd4, 8'd2, 1'b1, 2'b00);
    rx_frame(d1, ok1, n1);
    check("t3_rx_ok", 48'(ok1), 48'd1);
    check("t3_bytes", d1, 48'h82_80_02_04_04_A5);
    wait_done(ok1);
    check("t3_done_seen", 48'(ok1), 48'd1);

    // 4: count_a changes during byte 1
    set_inputs(8'd3, 8'd5, 8'd1, 1'b0, 2'b01);
    fork
      rx_frame(d1, ok1, n1);
      begin cyc(50); count_a = 8'hFF; end
    join
    check("t4_bytes", d1, 48'h06_01_01_05_03_A5);
    wait_done(ok1);
    check("t4_done_seen", 48'(ok1), 48'd1);
    count_a = 8'd3;
    cyc(2);

    // 5: resend while busy ignored; resend in the done cycle restarts at once
    done_cnt = 0;
    resend = 1'b1; cyc(1); resend = 1'b0;
    fork
      rx_frame(d1, ok1, n1);
      begin cyc(100); resend = 1'b1; cyc(1); resend = 1'b0; end
    join
    check("t5_bytes_a", d1, 48'h06_01_01_05_03_A5);
    wait_done(ok1);
    check("t5_done_seen", 48'(ok1), 48'd1);
    resend = 1'b1;
    @(posedge clk); #1;
    resend = 1'b0;
    rx_frame(d1, ok1, n1);
    check("t5_retrig_gap", 48'(n1), 48'd0);
    check("t5_bytes_b", d1, 48'h06_01_01_05_03_A5);
    wait_done(ok1);
    check("t5_done_pulses", 48'(done_cnt), 48'd2);

    // 6: reset during byte 2, then automatic resend
    set_inputs(8'd3, 8'd5, 8'd1, 1'b0, 2'b01);
    cyc(90);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t6_rst_tx", 48'(tx), 48'd1);
    check("t6_rst_busy", 48'(tx_busy), 48'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    rx_frame(d1, ok1, n1);
    check("t6_restart_gap", 48'(n1), 48'd1);
    check("t6_no_done_abort", 48'(done_cnt), 48'd0);
    check("t6_bytes", d1, 48'h06_01_01_05_03_A5);
    wait_done(ok1);
    check("t6_done_seen", 48'(ok1), 48'd1);

    // randomized frames with mid-frame disturbances
    for (int it = 0; it < 20; it++) begin
      int mode;
      set_inputs(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
                 2'($urandom_range(0, 2)));
      mode = $urandom_range(0, 3);
      cyc($urandom_range(1, 250));
      case (mode)
        1: begin resend = 1'b1; cyc($urandom_range(1, 3)); resend = 1'b0; end
        2: begin
          count_a = 8'($urandom); count_b = 8'($urandom); count_c = 8'($urandom);
          tie_flag = 1'($urandom); winner = 2'($urandom_range(0, 3));
        end
        3: begin reset_n = 1'b0; cyc($urandom_range(1, 3)); reset_n = 1'b1; end
        default: ;
      endcase
      wait_idle();
      if ($urandom_range(0, 1) == 1 && winner != 2'b11) begin
        resend = 1'b1; cyc(1); resend = 1'b0;
        wait_idle();
      end
      cyc(2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
